// File: rtl/leitor_registradores.sv
// Register-bank read stage for ID: 32x32 register file, WB write port, two bypassed read ports
// and a per-register 2-bit pending-write scoreboard that gates acceptance of decoded reads.
module leitor_registradores #(
    parameter int N_REG   = 32,
    parameter int LARGURA = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               habilita_escrita,
    input  logic [4:0]         end_escrita,
    input  logic [LARGURA-1:0] dado_escrita,
    input  logic               cancelar,
    input  logic [4:0]         end_cancelado,
    input  logic               leitura_valida,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [4:0]         rd,
    input  logic               escreve_rd,
    output logic               pronto,
    output logic               saida_valida,
    output logic [LARGURA-1:0] dado_rs1,
    output logic [LARGURA-1:0] dado_rs2,
    output logic [4:0]         rd_saida
);

    logic [LARGURA-1:0] banco [N_REG];
    logic [1:0]         pend  [N_REG];
    logic [1:0]         pend_prox [N_REG];
    logic [1:0]         decremento [N_REG];
    logic [1:0]         efetivo [N_REG];
    logic [N_REG-1:0]   dec_wb;
    logic [N_REG-1:0]   dec_can;
    logic [N_REG-1:0]   inc;

    logic               hazard_rs1;
    logic               hazard_rs2;
    logic               saturacao;
    logic               aceita;
    logic [LARGURA-1:0] operando1;
    logic [LARGURA-1:0] operando2;

    // Pending count as seen by this cycle's request: retiring producers already count as done.
    always_comb begin
        for (int i = 0; i < N_REG; i++) begin
            dec_wb[i]     = habilita_escrita && (end_escrita == 5'(i)) && (i != 0);
            dec_can[i]    = cancelar && (end_cancelado == 5'(i)) && (i != 0);
            decremento[i] = {1'b0, dec_wb[i]} + {1'b0, dec_can[i]};
            efetivo[i]    = (pend[i] < decremento[i]) ? 2'd0 : pend[i] - decremento[i];
        end
    end

    assign hazard_rs1 = (rs1 != 5'd0) && (efetivo[rs1] != 2'd0);
    assign hazard_rs2 = (rs2 != 5'd0) && (efetivo[rs2] != 2'd0);
    assign saturacao  = escreve_rd && (rd != 5'd0) && (pend[rd] == 2'd3)
                        && !dec_wb[rd] && !dec_can[rd];
    assign pronto     = !hazard_rs1 && !hazard_rs2 && !saturacao;
    assign aceita     = leitura_valida && pronto;

    // Increment and decrements are summed; the result is floored at zero.
    always_comb begin
        for (int i = 0; i < N_REG; i++) begin
            logic [2:0] soma;
            inc[i]       = aceita && escreve_rd && (rd == 5'(i)) && (i != 0);
            soma         = {1'b0, pend[i]} + {2'b00, inc[i]};
            pend_prox[i] = (soma < {1'b0, decremento[i]}) ? 2'd0
                                                          : 2'(soma - {1'b0, decremento[i]});
        end
    end

    always_comb begin
        if (rs1 == 5'd0)
            operando1 = '0;
        else if (habilita_escrita && (end_escrita == rs1))
            operando1 = dado_escrita;
        else
            operando1 = banco[rs1];

        if (rs2 == 5'd0)
            operando2 = '0;
        else if (habilita_escrita && (end_escrita == rs2))
            operando2 = dado_escrita;
        else
            operando2 = banco[rs2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REG; i++) begin
                banco[i] <= '0;
                pend[i]  <= 2'd0;
            end
            saida_valida <= 1'b0;
            dado_rs1     <= '0;
            dado_rs2     <= '0;
            rd_saida     <= 5'd0;
        end else begin
            if (habilita_escrita && (end_escrita != 5'd0))
                banco[end_escrita] <= dado_escrita;
            for (int i = 0; i < N_REG; i++)
                pend[i] <= pend_prox[i];
            saida_valida <= aceita;
            if (aceita) begin
                dado_rs1 <= operando1;
                dado_rs2 <= operando2;
                rd_saida <= rd;
            end
        end
    end

endmodule

// File: tb/tb_leitor_registradores.sv
// Directed bench for leitor_registradores: x0, bypass, load-use stall, saturation,
// cancel/underflow and reset mid-stall, with hand-computed expectations.
module tb_leitor_registradores;

    logic        clk = 1'b0;
    logic        reset;
    logic        habilita_escrita;
    logic [4:0]  end_escrita;
    logic [31:0] dado_escrita;
    logic        cancelar;
    logic [4:0]  end_cancelado;
    logic        leitura_valida;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        escreve_rd;
    logic        pronto;
    logic        saida_valida;
    logic [31:0] dado_rs1;
    logic [31:0] dado_rs2;
    logic [4:0]  rd_saida;

    int checks = 0;
    int erros  = 0;

    leitor_registradores #(.N_REG(32), .LARGURA(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .habilita_escrita (habilita_escrita),
        .end_escrita      (end_escrita),
        .dado_escrita     (dado_escrita),
        .cancelar         (cancelar),
        .end_cancelado    (end_cancelado),
        .leitura_valida   (leitura_valida),
        .rs1              (rs1),
        .rs2              (rs2),
        .rd               (rd),
        .escreve_rd       (escreve_rd),
        .pronto           (pronto),
        .saida_valida     (saida_valida),
        .dado_rs1         (dado_rs1),
        .dado_rs2         (dado_rs2),
        .rd_saida         (rd_saida)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            erros++;
            $display("FAIL %s: obtido %h esperado %h", tag, obtido, esperado);
        end
    endtask

    task automatic ocioso();
        habilita_escrita = 1'b0;
        end_escrita      = 5'd0;
        dado_escrita     = 32'd0;
        cancelar         = 1'b0;
        end_cancelado    = 5'd0;
        leitura_valida   = 1'b0;
        rs1              = 5'd0;
        rs2              = 5'd0;
        rd               = 5'd0;
        escreve_rd       = 1'b0;
    endtask

    task automatic passo();
        @(posedge clk);
        #1;
    endtask

    task automatic pede(input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] dst, input logic esc);
        leitura_valida = 1'b1;
        rs1            = a1;
        rs2            = a2;
        rd             = dst;
        escreve_rd     = esc;
    endtask

    task automatic escreve(input logic [4:0] a, input logic [31:0] d);
        habilita_escrita = 1'b1;
        end_escrita      = a;
        dado_escrita     = d;
    endtask

    initial begin
        ocioso();
        reset = 1'b1;
        passo();
        passo();
        verifica("reset_saida_valida", {31'd0, saida_valida}, 32'd0);
        verifica("reset_rd_saida", {27'd0, rd_saida}, 32'd0);
        verifica("reset_dado_rs1", dado_rs1, 32'd0);
        reset = 1'b0;

        // 1: x0 reads as zero, writes to x0 discarded
        pede(5'd0, 5'd5, 5'd0, 1'b0);
        #1 verifica("t1_pronto", {31'd0, pronto}, 32'd1);
        passo();
        verifica("t1_valida", {31'd0, saida_valida}, 32'd1);
        verifica("t1_rs1", dado_rs1, 32'd0);
        verifica("t1_rs2", dado_rs2, 32'd0);
        ocioso();
        escreve(5'd0, 32'hDEADBEEF);
        passo();
        verifica("t1_sem_pulso", {31'd0, saida_valida}, 32'd0);
        ocioso();
        pede(5'd0, 5'd0, 5'd0, 1'b0);
        passo();
        verifica("t1_x0_rs1", dado_rs1, 32'd0);

        // 2: write then read, and same-cycle bypass
        ocioso();
        escreve(5'd7, 32'h12345678);
        passo();
        ocioso();
        pede(5'd7, 5'd0, 5'd0, 1'b0);
        passo();
        verifica("t2_le_x7", dado_rs1, 32'h12345678);
        ocioso();
        pede(5'd7, 5'd9, 5'd0, 1'b0);
        escreve(5'd9, 32'hCAFEF00D);
        passo();
        verifica("t2_bypass_rs2", dado_rs2, 32'hCAFEF00D);
        verifica("t2_rs1_x7", dado_rs1, 32'h12345678);
        ocioso();
        pede(5'd9, 5'd0, 5'd0, 1'b0);
        passo();
        verifica("t2_x9_gravado", dado_rs1, 32'hCAFEF00D);

        // 3: load-use stall released by WB
        ocioso();
        pede(5'd0, 5'd0, 5'd3, 1'b1);
        passo();
        verifica("t3_prod_valida", {31'd0, saida_valida}, 32'd1);
        verifica("t3_prod_rd", {27'd0, rd_saida}, 32'd3);
        ocioso();
        pede(5'd3, 5'd0, 5'd0, 1'b0);
        #1 verifica("t3_pronto_c1", {31'd0, pronto}, 32'd0);
        passo();
        verifica("t3_parado_c1", {31'd0, saida_valida}, 32'd0);
        verifica("t3_pronto_c2", {31'd0, pronto}, 32'd0);
        passo();
        escreve(5'd3, 32'hA5A5A5A5);
        #1 verifica("t3_pronto_c3", {31'd0, pronto}, 32'd1);
        passo();
        verifica("t3_valida", {31'd0, saida_valida}, 32'd1);
        verifica("t3_rs1", dado_rs1, 32'hA5A5A5A5);
        verifica("t3_rd_saida", {27'd0, rd_saida}, 32'd0);
        ocioso();
        pede(5'd3, 5'd0, 5'd0, 1'b0);
        #1 verifica("t3_pend_zero", {31'd0, pronto}, 32'd1);
        ocioso();
        passo();
        verifica("t3_um_pulso", {31'd0, saida_valida}, 32'd0);

        // 4: three producers of x4 saturate the counter
        for (int k = 0; k < 3; k++) begin
            pede(5'd0, 5'd0, 5'd4, 1'b1);
            #1 verifica("t4_aceita_prod", {31'd0, pronto}, 32'd1);
            passo();
        end
        #1 verifica("t4_saturado", {31'd0, pronto}, 32'd0);
        passo();
        verifica("t4_sat_sem_pulso", {31'd0, saida_valida}, 32'd0);
        ocioso();
        escreve(5'd4, 32'h00000041);
        passo();
        ocioso();
        pede(5'd4, 5'd0, 5'd0, 1'b0);
        #1 verifica("t4_pend2_para", {31'd0, pronto}, 32'd0);
        escreve(5'd4, 32'h00000042);
        #1 verifica("t4_pend2_wb", {31'd0, pronto}, 32'd0);
        passo();
        escreve(5'd4, 32'h00000043);
        #1 verifica("t4_ultimo_wb", {31'd0, pronto}, 32'd1);
        passo();
        verifica("t4_valida", {31'd0, saida_valida}, 32'd1);
        verifica("t4_rs1", dado_rs1, 32'h00000043);

        // 5: cancel plus WB on same register, cancel with nothing pending
        ocioso();
        pede(5'd0, 5'd0, 5'd6, 1'b1);
        passo();
        ocioso();
        escreve(5'd6, 32'h00000066);
        cancelar      = 1'b1;
        end_cancelado = 5'd6;
        passo();
        ocioso();
        pede(5'd6, 5'd0, 5'd0, 1'b0);
        #1 verifica("t5_x6_livre", {31'd0, pronto}, 32'd1);
        passo();
        verifica("t5_rs1", dado_rs1, 32'h00000066);
        ocioso();
        cancelar      = 1'b1;
        end_cancelado = 5'd10;
        passo();
        ocioso();
        pede(5'd10, 5'd0, 5'd10, 1'b1);
        #1 verifica("t5_x10_sem_wrap", {31'd0, pronto}, 32'd1);
        passo();
        ocioso();
        pede(5'd10, 5'd0, 5'd0, 1'b0);
        #1 verifica("t5_x10_pend1", {31'd0, pronto}, 32'd0);

        // 6: reset during a stall on x3
        ocioso();
        pede(5'd0, 5'd0, 5'd3, 1'b1);
        passo();
        ocioso();
        pede(5'd3, 5'd0, 5'd0, 1'b0);
        #1 verifica("t6_parado", {31'd0, pronto}, 32'd0);
        passo();
        reset = 1'b1;
        passo();
        verifica("t6_reset_valida", {31'd0, saida_valida}, 32'd0);
        reset = 1'b0;
        #1 verifica("t6_pronto_pos", {31'd0, pronto}, 32'd1);
        passo();
        verifica("t6_valida", {31'd0, saida_valida}, 32'd1);
        verifica("t6_rs1_zero", dado_rs1, 32'd0);

        ocioso();
        passo();
        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

endmodule

// File: doc/leitor_registradores.md
# leitor_registradores

Register-bank read stage for the ID pipeline stage: a 32×32-bit architectural register file with:
- one write port, driven by WB;
- two read ports, serving the decoded instruction;
- a per-register pending-write scoreboard.

It accepts a decoded read request only when both source operands are free of outstanding producers. It then delivers the operands, with WB write-through bypass, one cycle later to the ID/EX boundary. It is the read-side counterpart of the write-enabled architectural register element.

## Interface
- N_REG, 32, number of architectural registers (x0 hardwired to zero)
- LARGURA, 32, data width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- habilita_escrita  in  1  WB write strobe
- end_escrita  in  5  WB destination register
- dado_escrita  in  LARGURA  WB data
- cancelar  in  1  squashed producer retires without writing
- end_cancelado  in  5  destination of squashed producer
- leitura_valida  in  1  decoded instruction presents a read request
- rs1, rs2  in  5  source register addresses
- rd  in  5  destination address of the requesting instruction
- escreve_rd  in  1  requesting instruction will write rd
- pronto  out  1  request can be accepted this cycle (combinational)
- saida_valida  out  1  operands valid at ID/EX
- dado_rs1, dado_rs2  out  LARGURA  operand values
- rd_saida  out  5  registered copy of accepted rd

## Operation
**Register file**
- On `habilita_escrita` with `end_escrita != 0`, `reg[end_escrita] <= dado_escrita`.
- Writes to x0 are discarded; reads of x0 return 0.

**Scoreboard**
- One 2-bit counter `pend[i]` per register; x0 is never counted.
- `efetivo(r) = pend[r] − (habilita_escrita && end_escrita==r) − (cancelar && end_cancelado==r)`, floored at 0.

**Hazard and accept**
- Source hazard on `rsX`: `rsX != 0` and `efetivo(rsX) != 0`.
- Destination saturation: `escreve_rd`, `rd != 0`, and `pend[rd] == 3` and no decrement of `rd` this cycle.
- `pronto = !hazard_rs1 && !hazard_rs2 && !saturation`. It is independent of `leitura_valida`.
- `aceita = leitura_valida && pronto`.

**Counter update, per register i ≠ 0, same edge**
- +1 if `aceita && escreve_rd && rd == i`.
- −1 if WB writes i.
- −1 if cancel targets i.
- All contributions are summed.
- A decrement when the count is 0 is ignored (no underflow).
- WB and cancel to the same register in the same cycle give −2, floored at 0.

**Operand selection**
- If `rsX == 0`: 0.
- Else if WB is writing `rsX` this cycle: `dado_escrita` (bypass).
- Else: `reg[rsX]`.

**Output register**
- On `aceita`: `saida_valida <= 1`, `dado_rs1/2 <=` selected values, `rd_saida <= rd`.
- Otherwise `saida_valida <= 0` and the data/`rd_saida` hold their previous values.

**Reset**
- All `reg[i] = 0`, all `pend[i] = 0`.
- `saida_valida = 0`, `dado_rs1 = dado_rs2 = 0`, `rd_saida = 0`.
- Reset dominates all other inputs in the same cycle.

## Timing
- Latency: request accepted at edge N → operands valid after edge N, `saida_valida` high for exactly one cycle per accept.
- Throughput: one accept per cycle when hazard-free.
- Stall: the requester holds `rs1`/`rs2`/`rd`/`escreve_rd` stable while `leitura_valida && !pronto`. The block samples nothing while stalled.
- Load-use release: WB of the last producer of `rs1` in cycle N makes `pronto` high in cycle N, and the bypassed value is captured at the end of N.
- Self-dependence: for `rs1 == rd` with `escreve_rd`, the hazard is checked against `pend` before this request's increment. The instruction is not blocked by its own write.
- Simultaneous accept increment and WB decrement of the same register: the net count is unchanged.
- Reset asserted mid-stall: the next cycle has `pronto = 1` (all counts 0) and `saida_valida = 0`.

## Test plan
1. **Reset and x0 behaviour.**
   - Stimulus: hold `reset` 2 cycles. Release, then request `rs1=0`, `rs2=5`. Then WB writes x0 with `0xDEADBEEF`. Then request `rs1=0` again.
   - Response: after the first request, `saida_valida=1`, `dado_rs1=0`, `dado_rs2=0`. After the x0 write and second request, `dado_rs1=0`.
2. **Write then read, with same-cycle bypass.**
   - Stimulus: WB writes x7=`0x12345678`; next cycle read `rs1=7`. Separately, WB writes x9=`0xCAFEF00D` in the same cycle as a read of `rs2=9`.
   - Response: `dado_rs1=0x12345678`; `dado_rs2=0xCAFEF00D`.
3. **Load-use stall and release.**
   - Stimulus: accept a producer with `rd=3`, `escreve_rd=1`. Next request has `rs1=3`; hold it 3 cycles. In the 3rd cycle WB writes x3=`0xA5A5A5A5`.
   - Response: `pronto=0` for cycles 1–2, `pronto=1` in cycle 3. One `saida_valida` pulse with `dado_rs1=0xA5A5A5A5`. `pend[3]=0` afterwards.
4. **Counter saturation and multiple producers.**
   - Stimulus: accept 3 requests with `rd=4`, then present a 4th.
   - Response: `pronto=0` on the 4th request until one WB to x4. After the first WB, a read of `rs1=4` still stalls because `pend[4]=2`.
5. **Cancel and underflow.**
   - Stimulus: accept a producer with `rd=6`, then assert `cancelar` with `end_cancelado=6` while WB also writes x6. In a separate cycle, cancel x10 with `pend[10]=0`.
   - Response: `pend[6]=0` with no wrap. `pend[10]` stays 0. A read of `rs1=6` is accepted immediately.
6. **Reset mid-stall.**
   - Stimulus: a stall is pending on x3; assert `reset` for 1 cycle with `leitura_valida` held.
   - Response: during reset `saida_valida=0`. In the cycle after reset `pronto=1`. The held request is accepted with `dado_rs1=0`.
